// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between
// the ALU writeback path (requester 0) and the load/store unit (requester 1).
// Each requester owns a one-entry holding slot; occupied slots are picked
// round-robin into a registered write-port driver. A saturating counter
// records cycles in which both slots are occupied.
// Build option: define WB_BYPASS_EN to forward the write being presented to
// the register file onto the read-data outputs in the same cycle; without
// it the read data passes straight through.
module regfile_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_addr_rd,
   output logic [XLEN-1:0]       rf_data_rd,
   output logic [CNT_W-1:0]      conflict_cnt,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [XLEN-1:0]       rf_rdata1,
   input  logic [XLEN-1:0]       rf_rdata2,
   output logic [XLEN-1:0]       fwd_data1,
   output logic [XLEN-1:0]       fwd_data2
);

   // Slot state: valid bits are control (reset), rd/data are payload (no reset).
   logic                  alu_v_q, alu_v_d;
   logic [REG_ADDR_W-1:0] alu_rd_q, alu_rd_d;
   logic [XLEN-1:0]       alu_data_q, alu_data_d;
   logic                  lsu_v_q, lsu_v_d;
   logic [REG_ADDR_W-1:0] lsu_rd_q, lsu_rd_d;
   logic [XLEN-1:0]       lsu_data_q, lsu_data_d;

   // Arbitration and write-port state. last_grant: 0 = ALU won last, 1 = LSU.
   logic                  last_grant_q, last_grant_d;
   logic                  rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [XLEN-1:0]       rf_data_q, rf_data_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic grant_alu, grant_lsu;
   logic alu_fire, lsu_fire;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Round-robin grant from registered slot state only, so ready never
   // depends combinationally on valid.
   always_comb begin
      grant_alu = alu_v_q && (!lsu_v_q || last_grant_q);
      grant_lsu = lsu_v_q && (!alu_v_q || !last_grant_q);
   end

   // A slot can accept when empty or when it is being drained this cycle.
   assign alu_ready = !rst && (!alu_v_q || grant_alu);
   assign lsu_ready = !rst && (!lsu_v_q || grant_lsu);
   assign alu_fire  = alu_valid && alu_ready;
   assign lsu_fire  = lsu_valid && lsu_ready;

   // Slot next state: drain on grant, refill on handshake; writes to x0 are
   // accepted but never stored.
   always_comb begin
      alu_v_d    = alu_v_q;
      alu_rd_d   = alu_rd_q;
      alu_data_d = alu_data_q;
      lsu_v_d    = lsu_v_q;
      lsu_rd_d   = lsu_rd_q;
      lsu_data_d = lsu_data_q;
      if (grant_alu) alu_v_d = 1'b0;
      if (grant_lsu) lsu_v_d = 1'b0;
      if (alu_fire && (alu_rd != '0)) begin
         alu_v_d    = 1'b1;
         alu_rd_d   = alu_rd;
         alu_data_d = alu_data;
      end
      if (lsu_fire && (lsu_rd != '0)) begin
         lsu_v_d    = 1'b1;
         lsu_rd_d   = lsu_rd;
         lsu_data_d = lsu_data;
      end
   end

   // Write-port driver next state; address/data hold when nothing is granted.
   always_comb begin
      rf_we_d      = 1'b0;
      rf_addr_d    = rf_addr_q;
      rf_data_d    = rf_data_q;
      last_grant_d = last_grant_q;
      if (grant_alu) begin
         rf_we_d      = 1'b1;
         rf_addr_d    = alu_rd_q;
         rf_data_d    = alu_data_q;
         last_grant_d = 1'b0;
      end else if (grant_lsu) begin
         rf_we_d      = 1'b1;
         rf_addr_d    = lsu_rd_q;
         rf_data_d    = lsu_data_q;
         last_grant_d = 1'b1;
      end
      cnt_d = (alu_v_q && lsu_v_q) ? sat_inc(cnt_q) : cnt_q;
   end

   // Control and write-port registers, cleared by asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_v_q      <= 1'b0;
         lsu_v_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rf_we_q      <= 1'b0;
         rf_addr_q    <= '0;
         rf_data_q    <= '0;
         cnt_q        <= '0;
      end else begin
         alu_v_q      <= alu_v_d;
         lsu_v_q      <= lsu_v_d;
         last_grant_q <= last_grant_d;
         rf_we_q      <= rf_we_d;
         rf_addr_q    <= rf_addr_d;
         rf_data_q    <= rf_data_d;
         cnt_q        <= cnt_d;
      end
   end

   // Slot payload registers; meaningful only while the matching valid is set.
   always_ff @(posedge clk) begin
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      lsu_rd_q   <= lsu_rd_d;
      lsu_data_q <= lsu_data_d;
   end

   assign rf_we        = rf_we_q;
   assign rf_addr_rd   = rf_addr_q;
   assign rf_data_rd   = rf_data_q;
   assign conflict_cnt = cnt_q;

`ifdef WB_BYPASS_EN
   // Same-cycle forwarding of the write being presented to the register file.
   assign fwd_data1 = (rf_we_q && (rf_addr_q == rs1_addr) && (rs1_addr != '0)) ? rf_data_q : rf_rdata1;
   assign fwd_data2 = (rf_we_q && (rf_addr_q == rs2_addr) && (rs2_addr != '0)) ? rf_data_q : rf_rdata2;
`else
   // Read addresses only matter when forwarding is built in.
   logic unused_rs_addr;
   assign unused_rs_addr = ^{rs1_addr, rs2_addr};
   assign fwd_data1 = rf_rdata1;
   assign fwd_data2 = rf_rdata2;
`endif

endmodule
